operand_source: RTL and testbench
=================================

# operand_source

Producer end of the `_dav`/`rfd` four-phase handshake used by the team's operand consumers, such as the `2*(a+b)` adder unit. On `start` it generates 32 operand pairs from an index counter and delivers each one across the handshake. After each transfer it captures the consumer's 6-bit result `p` and checks it against the expected value, counting mismatches. It acts as an on-chip self-test source in front of any consumer that uses this protocol.

## Interface
- `SETUP_CYCLES`, default 1: clock cycles that `a`/`b` must be stable before `_dav` falls; legal range is 1..15.
- `TIMEOUT`, default 255: maximum cycles to wait in a handshake phase before aborting; legal range is 1..255.
- `clock`  in  1: the single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: level input, sampled only in IDLE or DONE; begins a run of 32 pairs.
- `rfd`  in  1: consumer ready-for-data.
- `p`  in  6: consumer result; valid when `rfd` returns to 1.
- `_dav`  out  1: data-available, active-low.
- `a`  out  4: first operand.
- `b`  out  4: second operand.
- `busy`  out  1: 1 from start acceptance until DONE.
- `done`  out  1: 1 in DONE.
- `timeout`  out  1: sticky; set when a run aborts on timeout.
- `err_count`  out  6: number of result mismatches in the current run, saturating at 63.

## Operation
- Reset values: `_dav`=1, `a`=0, `b`=0, `busy`=0, `done`=0, `timeout`=0, `err_count`=0; state IDLE, index 0.
- Pair for index i (5-bit): `a` = i[4:1]+3 mod 16, `b` = i[3:0]+1 mod 16.
- Expected result: `exp` = 2*(a+b), computed in 6 bits (maximum 60, no overflow).
- States:
  - IDLE: on `start`=1, go to SETUP. Clear index, `err_count`, `timeout` and `done`; load pair 0; set `busy`=1.
  - SETUP: hold `a`/`b`. Leave only when the phase counter has reached `SETUP_CYCLES` and `rfd`=1. Then set `_dav`=0 and go to DAV.
  - DAV: wait for `rfd`=0. On that edge set `_dav`=1 and go to WAIT.
  - WAIT: wait for `rfd`=1. On that edge capture `p` and go to CHECK.
  - CHECK (one cycle): if captured `p` ≠ `exp`, increment `err_count`.
    - If index = 31: go to DONE.
    - Otherwise: increment index, load the next pair into `a`/`b`, go to SETUP.
  - DONE: `busy`=0, `done`=1, outputs held. On `start`=1, behave exactly as IDLE.
- `a`/`b` change only on entry to SETUP. They are never altered while `_dav`=0 or while `rfd`=0.
- Timeout: the phase counter clears on every state entry and counts while in DAV or WAIT. When it reaches `TIMEOUT`:
  - set `timeout`=1 and `_dav`=1;
  - go to DONE without checking.
  - `err_count` keeps its value.
- `start` while `busy`=1 is ignored.
- Reset asserted mid-run: all outputs return to their reset values immediately, asynchronously. `_dav` must go to 1 without waiting for a clock edge.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Edge k samples `start`=1 → `a`/`b` valid and `busy`=1 after edge k.
- `_dav` falls at edge k+`SETUP_CYCLES`, provided `rfd`=1 at that edge; otherwise it falls at the first later edge that samples `rfd`=1.
- `_dav` rises at the first edge that samples `rfd`=0; `p` is captured at the first edge that then samples `rfd`=1.
- Minimum cycles per pair: `SETUP_CYCLES` + 3, with an ideal consumer.
- Boundary behaviour:
  - Index wrap 31→0 does not occur within a run.
  - Pair 31 is `a`=2, `b`=0, `exp`=4.
  - `err_count` saturates at 63.

## Structure
- Shared header `operand_source_defs.vh` holds:
  - state encodings: IDLE, SETUP, DAV, WAIT, CHECK, DONE;
  - pair/expected-result function `get_pair` (index → {a, b, exp}), also usable by benches.
- One sub-module, `phase_timer`: 8-bit counter with synchronous clear, enable, and a terminal-count compare output. It is used for both the SETUP hold and the timeouts.

## Test plan
- Reset then idle: `reset` pulse → `_dav`=1, `a`=`b`=0, `busy`=`done`=0; nothing changes while `start`=0.
- Full run with correct consumer model (`p`=2*(a+b), `rfd` low 1 cycle after `_dav` falls, high 3 cycles after `_dav` rises):
  - 32 transfers, first pair `a`=3 `b`=1 `p`=8, last pair `a`=2 `b`=0 `p`=4;
  - ends with `done`=1, `err_count`=0, `timeout`=0.
- Faulty consumer returning `p`+1 on indices 5 and 20 → `err_count`=2 at `done`.
- Consumer holding `rfd`=0 at start → `_dav` stays 1 until `rfd`=1, then falls `SETUP_CYCLES` or more cycles after start.
- Consumer that never drops `rfd` after `_dav`=0, with `TIMEOUT`=255 → after 255 cycles `_dav`=1, `timeout`=1, `done`=1.
- `reset` asserted while `_dav`=0 at index 10 → `_dav`=1 asynchronously; a new `start` restarts from pair 0 (`a`=3, `b`=1).

Source files
------------

// File: rtl/operand_source_pkg.sv
// Shared definitions for operand_source: FSM state encoding and the
// index -> {a, b, expected result} mapping.
package operand_source_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        DAV   = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int unsigned NUM_PAIRS = 32;
    localparam logic [4:0]  LAST_IDX  = 5'd31;
    localparam logic [5:0]  ERR_MAX   = 6'd63;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [5:0] exp;
    } pair_t;

    // 2*(a+b) never exceeds 60, so the 5-bit sum plus a shift fits in 6 bits.
    function automatic pair_t get_pair(input logic [4:0] idx);
        pair_t pr;
        pr.a   = idx[4:1] + 4'd3;
        pr.b   = idx[3:0] + 4'd1;
        pr.exp = {({1'b0, pr.a} + {1'b0, pr.b}), 1'b0};
        return pr;
    endfunction

endpackage

// File: rtl/operand_source_phase_timer.sv
// 8-bit phase counter with synchronous clear, enable and a
// terminal-count compare; saturates instead of wrapping.
module phase_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] terminal,
    output logic [7:0] count,
    output logic       reached
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && (count != 8'hff)) begin
            count <= count + 8'd1;
        end
    end

    assign reached = (count >= terminal);

endmodule

// File: rtl/operand_source.sv
// Self-test producer for the _dav/rfd four-phase handshake: sends 32 operand
// pairs, captures each result p and counts mismatches against 2*(a+b).
module operand_source
    import operand_source_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rfd,
    input  logic [5:0] p,
    output logic       _dav,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [5:0] err_count
);

    // Counter value v before an edge means v+1 cycles spent in the phase.
    localparam logic [7:0] SETUP_TC   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT - 1);

    state_t     state;
    logic [4:0] idx;
    logic [5:0] p_cap;

    logic       tmr_clear;
    logic       tmr_enable;
    logic [7:0] tmr_terminal;
    logic [7:0] tmr_count;
    logic       tmr_reached;

    pair_t      cur_pair;
    pair_t      next_pair;
    pair_t      first_pair;

    assign cur_pair   = get_pair(idx);
    assign next_pair  = get_pair(idx + 5'd1);
    assign first_pair = get_pair(5'd0);

    // Clear on every transition so each state is entered with a zero count.
    always_comb begin
        tmr_clear    = 1'b1;
        tmr_enable   = 1'b0;
        tmr_terminal = TIMEOUT_TC;
        unique case (state)
            SETUP: begin
                tmr_enable   = 1'b1;
                tmr_terminal = SETUP_TC;
                tmr_clear    = tmr_reached && rfd;
            end
            DAV: begin
                tmr_enable = 1'b1;
                tmr_clear  = !rfd || tmr_reached;
            end
            WAIT: begin
                tmr_enable = 1'b1;
                tmr_clear  = rfd || tmr_reached;
            end
            default: begin
                tmr_clear = 1'b1;
            end
        endcase
    end

    phase_timer u_phase_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (tmr_clear),
        .enable   (tmr_enable),
        .terminal (tmr_terminal),
        .count    (tmr_count),
        .reached  (tmr_reached)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 5'd0;
            p_cap     <= 6'd0;
            _dav      <= 1'b1;
            a         <= 4'd0;
            b         <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= 6'd0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx       <= 5'd0;
                        err_count <= 6'd0;
                        timeout   <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        a         <= first_pair.a;
                        b         <= first_pair.b;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr_reached && rfd) begin
                        _dav  <= 1'b0;
                        state <= DAV;
                    end
                end
                DAV: begin
                    if (!rfd) begin
                        _dav  <= 1'b1;
                        state <= WAIT;
                    end else if (tmr_reached) begin
                        _dav    <= 1'b1;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                WAIT: begin
                    if (rfd) begin
                        p_cap <= p;
                        state <= CHECK;
                    end else if (tmr_reached) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                CHECK: begin
                    if ((p_cap != cur_pair.exp) && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 6'd1;
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 5'd1;
                        a     <= next_pair.a;
                        b     <= next_pair.b;
                        state <= SETUP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_source.sv
// Self-checking bench for operand_source: a behavioural consumer drives the
// handshake, and results are compared against an arithmetic reference model.
module tb_operand_source;

    localparam int unsigned SETUP = 2;
    localparam int unsigned TMO   = 255;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rfd   = 1'b1;
    logic [5:0] p     = 6'd0;
    logic       _dav;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [5:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int viol    = 0;
    int perr_tab[32];

    typedef struct {
        int f0;
        int f1;
        int all_bad;
        int drop_dly;
        int rise_dly;
        int exp_err;
    } run_vec_t;

    run_vec_t vecs[5];

    operand_source #(
        .SETUP_CYCLES (SETUP),
        .TIMEOUT      (TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rfd       (rfd),
        .p         (p),
        ._dav      (_dav),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .err_count (err_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Operands must not move across an edge while _dav or rfd is low during a run.
    initial begin
        logic       pd, pr, pb;
        logic [3:0] pa, pbv;
        forever begin
            @(posedge clock);
            pd = _dav; pr = rfd; pb = busy; pa = a; pbv = b;
            #1;
            if (!reset && pb && ((a != pa) || (b != pbv)) && (!pd || !pr)) viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int ref_a(input int i);
        return ((i / 2) + 3) % 16;
    endfunction

    function automatic int ref_b(input int i);
        return ((i % 16) + 1) % 16;
    endfunction

    function automatic int ref_exp(input int i);
        return 2 * (ref_a(i) + ref_b(i));
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge where rfd has been raised again.
    task automatic do_transfer(input int idx, input int perr, input int drop_dly,
                               input int rise_dly, output int low_cyc, output bit ok);
        int n;
        ok = 1'b0;
        low_cyc = -1;
        n = 0;
        while (_dav !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (_dav !== 1'b0) begin
            check($sformatf("dav_fall_wait[%0d]", idx), int'(_dav), 0);
            return;
        end
        low_cyc = cyc;
        check($sformatf("a[%0d]", idx), int'(a), ref_a(idx));
        check($sformatf("b[%0d]", idx), int'(b), ref_b(idx));
        repeat (drop_dly) @(negedge clock);
        rfd = 1'b0;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (_dav !== 1'b1 && n < 200);
        check($sformatf("dav_rise_latency[%0d]", idx), n, 1);
        p = 6'((ref_exp(idx) + perr) % 64);
        repeat (rise_dly) @(negedge clock);
        rfd = 1'b1;
        ok = 1'b1;
    endtask

    task automatic run_pairs(input int first, input int dlo, input int dhi, input int rlo,
                             input int rhi, output int first_low, output bit ok);
        int lc;
        ok = 1'b1;
        first_low = -1;
        for (int i = first; i < 32; i++) begin
            do_transfer(i, perr_tab[i], int'($urandom_range(dhi, dlo)),
                        int'($urandom_range(rhi, rlo)), lc, ok);
            if (i == first) first_low = lc;
            if (!ok) return;
        end
    endtask

    task automatic start_run(output int k);
        start = 1'b1;
        @(posedge clock);
        #1;
        k = cyc;
        start = 1'b0;
        @(negedge clock);
        check("start_busy", int'(busy), 1);
        check("start_a", int'(a), 3);
        check("start_b", int'(b), 1);
        check("start_timeout_clear", int'(timeout), 0);
        check("start_err_clear", int'(err_count), 0);
    endtask

    task automatic expect_done(input int exp_err, input int exp_to);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("done", int'(done), 1);
        check("done_busy", int'(busy), 0);
        check("done_err_count", int'(err_count), exp_err);
        check("done_timeout", int'(timeout), exp_to);
        check("done_dav", int'(_dav), 1);
        if (exp_to == 0) begin
            check("last_a", int'(a), 2);
            check("last_b", int'(b), 0);
        end
    endtask

    initial begin
        int  k, lc, n, c, nbad, lows;
        bit  ok;

        vecs[0] = '{-1, -1, 0, 1, 3, 0};
        vecs[1] = '{ 5, 20, 0, 1, 3, 2};
        vecs[2] = '{ 0, 31, 0, 0, 0, 2};
        vecs[3] = '{13, 13, 0, 2, 1, 1};
        vecs[4] = '{-1, -1, 1, 0, 2, 32};

        // Reset and idle
        #2 reset = 1'b1;
        @(negedge clock);
        check("rst_dav", int'(_dav), 1);
        check("rst_a", int'(a), 0);
        check("rst_b", int'(b), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_err", int'(err_count), 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("idle_busy", int'(busy), 0);
        check("idle_dav", int'(_dav), 1);
        check("idle_a", int'(a), 0);

        // Directed runs from the table
        foreach (vecs[v]) begin
            for (int i = 0; i < 32; i++) perr_tab[i] = vecs[v].all_bad;
            if (vecs[v].f0 >= 0) perr_tab[vecs[v].f0] = 1;
            if (vecs[v].f1 >= 0) perr_tab[vecs[v].f1] = 1;
            start_run(k);
            run_pairs(0, vecs[v].drop_dly, vecs[v].drop_dly, vecs[v].rise_dly,
                      vecs[v].rise_dly, lc, ok);
            check($sformatf("vec%0d_first_dav_cycle", v), lc - k, SETUP);
            expect_done(vecs[v].exp_err, 0);
        end

        // Randomized runs against the model
        for (int r = 0; r < 4; r++) begin
            nbad = 0;
            for (int i = 0; i < 32; i++) begin
                perr_tab[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(63, 1)) : 0;
                if (perr_tab[i] != 0) nbad++;
            end
            start_run(k);
            run_pairs(0, 0, 3, 0, 4, lc, ok);
            expect_done((nbad > 63) ? 63 : nbad, 0);
        end

        // Consumer holding rfd low at start
        for (int i = 0; i < 32; i++) perr_tab[i] = 0;
        rfd = 1'b0;
        start_run(k);
        lows = 0;
        repeat (6) begin
            @(negedge clock);
            if (_dav !== 1'b1) lows++;
        end
        check("rfd_low_dav_held", lows, 0);
        rfd = 1'b1;
        c = cyc;
        n = 0;
        while (_dav !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rfd_high_dav_fall_cycle", cyc - c, 1);
        check("rfd_high_setup_met", int'((cyc - k) >= SETUP), 1);
        run_pairs(0, 1, 1, 3, 3, lc, ok);
        expect_done(0, 0);

        // Consumer never drops rfd: timeout abort
        start_run(k);
        n = 0;
        while (_dav !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("tmo_dav_low", int'(_dav), 0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (_dav === 1'b0 && n < 400);
        check("tmo_cycles", n, TMO);
        expect_done(0, 1);
        start_run(k);
        run_pairs(0, 0, 0, 0, 0, lc, ok);
        expect_done(0, 0);

        // Asynchronous reset while _dav is low at index 10
        start_run(k);
        for (int i = 0; i < 10; i++) begin
            do_transfer(i, 0, 1, 1, lc, ok);
        end
        n = 0;
        while (_dav !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("mid_dav_low", int'(_dav), 0);
        check("mid_a10", int'(a), ref_a(10));
        #2 reset = 1'b1;
        #1;
        check("async_rst_dav", int'(_dav), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_a", int'(a), 0);
        check("async_rst_b", int'(b), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        start_run(k);
        run_pairs(0, 1, 1, 3, 3, lc, ok);
        expect_done(0, 0);

        check("operand_stability_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
